bit_serial_logic_engine: RTL and testbench



---
 rtl/bit_serial_logic_engine.sv | 134 +++++++++++++
 tb/tb_bit_serial_logic_engine.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_logic_engine.sv
// bit_serial_logic_engine
//
// Bit-serial sequencer for the ALU's one-bit logic slice. A request is taken
// through an input valid/ready handshake, then one result bit is evaluated per
// clock, LSB first. The assembled word and the chain carry-out are returned
// through an output valid/ready handshake.
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are high. Valid, once raised by this block, holds with stable data until the
// transfer. in_ready is high exactly in IDLE; out_valid exactly in DONE.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid/ready   request handshake
//   in_op1, in_op2   WIDTH-bit operands
//   in_opsel         000 AND, 001 OR, 010 XOR, 011 NOT op1, 1xx shift left
//   in_cin           shift-in bit (shift op only)
//   out_valid/ready  result handshake
//   out_result       assembled WIDTH-bit result (registered)
//   out_cout         chain carry-out (registered; 0 for logic ops)
//   busy             high in RUN and DONE
module bit_serial_logic_engine #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_op1,
    input  logic [WIDTH-1:0] in_op2,
    input  logic [2:0]       in_opsel,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op1_sh;
    logic [WIDTH-1:0] op2_sh;
    logic [WIDTH-1:0] res_sh;
    logic [2:0]       opsel_q;
    logic             carry;
    logic             bit_val;
    logic             accept;
    logic             last_bit;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign last_bit  = (state == RUN) && (cnt == CW'(WIDTH - 1));

    // Operands shift right each RUN edge, so bit i is always at position 0.
    always_comb begin
        bit_val = 1'b0;
        if (opsel_q[2]) begin
            bit_val = carry;
        end else begin
            case (opsel_q[1:0])
                2'b00:   bit_val = op1_sh[0] & op2_sh[0];
                2'b01:   bit_val = op1_sh[0] | op2_sh[0];
                2'b10:   bit_val = op1_sh[0] ^ op2_sh[0];
                default: bit_val = ~op1_sh[0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            op1_sh     <= '0;
            op2_sh     <= '0;
            res_sh     <= '0;
            opsel_q    <= '0;
            carry      <= 1'b0;
            out_result <= '0;
            out_cout   <= 1'b0;
        end else if (accept) begin
            op1_sh  <= in_op1;
            op2_sh  <= in_op2;
            opsel_q <= in_opsel;
            carry   <= in_cin;
            cnt     <= '0;
            res_sh  <= '0;
        end else if (state == RUN) begin
            op1_sh <= op1_sh >> 1;
            op2_sh <= op2_sh >> 1;
            // New bits enter at the MSB; after WIDTH edges bit 0 sits at the LSB.
            res_sh <= {bit_val, res_sh[WIDTH-1:1]};
            if (opsel_q[2]) begin
                carry <= op1_sh[0];
            end
            if (last_bit) begin
                // Counter holds at WIDTH-1 instead of wrapping.
                out_result <= {bit_val, res_sh[WIDTH-1:1]};
                out_cout   <= opsel_q[2] & op1_sh[0];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bit_serial_logic_engine.sv
module tb_bit_serial_logic_engine;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_op1 = '0;
    logic [W-1:0] in_op2 = '0;
    logic [2:0]   in_opsel = '0;
    logic         in_cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_result;
    logic         out_cout;
    logic         busy;

    bit_serial_logic_engine #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op1(in_op1), .in_op2(in_op2), .in_opsel(in_opsel), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_cout(out_cout), .busy(busy)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int         n_vec = 0;
    int         n_bad = 0;
    logic [W:0] exp_q[$];     // {cout, result}
    int         acc_q[$];     // edge numbers of accepts
    int         last_acc = 0;
    logic       prev_ov = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                last_acc = cyc + 1;
                acc_q.push_back(cyc + 1);
            end
            if (out_valid && !prev_ov)
                check("latency", 32'(cyc - last_acc), 32'(W));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_result: got %0h, required no output", {out_cout, out_result});
                end else begin
                    check("result", 32'({out_cout, out_result}), 32'(exp_q.pop_front()));
                end
            end
            prev_ov = out_valid;
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                         input logic ci, input logic [W:0] exp, input bit keep, input bit expect_out);
        int t;
        bit got;
        t = 0;
        got = 1'b0;
        in_op1 = a;
        in_op2 = b;
        in_opsel = op;
        in_cin = ci;
        in_valid = 1'b1;
        while (!got && t < 100) begin
            @(negedge clk);
            t++;
            if (in_ready && rst_n) got = 1'b1;
        end
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: got no accept, required accept within 100 cycles");
        end else if (expect_out) begin
            exp_q.push_back(exp);
        end
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_result"}, 32'(out_result), 32'd0);
        check({tag, "_out_cout"}, 32'(out_cout), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n_acc;
        int t;

        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Logic ops on 0xCA / 0x5F
        issue(8'hCA, 8'h5F, 3'b000, 1'b0, {1'b0, 8'h4A}, 1'b0, 1'b1);
        drain();
        issue(8'hCA, 8'h5F, 3'b001, 1'b0, {1'b0, 8'hDF}, 1'b0, 1'b1);
        drain();
        issue(8'hCA, 8'h5F, 3'b010, 1'b1, {1'b0, 8'h95}, 1'b0, 1'b1);
        drain();
        issue(8'hCA, 8'h5F, 3'b011, 1'b1, {1'b0, 8'h35}, 1'b0, 1'b1);
        drain();

        // Shift ops
        issue(8'h96, 8'h00, 3'b100, 1'b1, {1'b1, 8'h2D}, 1'b0, 1'b1);
        drain();
        issue(8'h7F, 8'hFF, 3'b111, 1'b0, {1'b0, 8'hFE}, 1'b0, 1'b1);
        drain();

        // Backpressure in DONE with in_valid pulsing
        out_ready = 1'b0;
        issue(8'h96, 8'h00, 3'b100, 1'b1, {1'b1, 8'h2D}, 1'b0, 1'b1);
        n_acc = acc_q.size();
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("bp_reach_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = ~in_valid;
            in_op1 = 8'(i * 37);
            in_opsel = 3'(i);
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_hold", 32'({out_cout, out_result}), 32'({1'b1, 8'h2D}));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_idle", 32'(in_ready), 32'd1);
        check("bp_no_extra_accept", 32'(acc_q.size()), 32'(n_acc));
        drain();

        // Back-to-back with in_valid and out_ready held high
        acc_q.delete();
        issue(8'h12, 8'h34, 3'b000, 1'b0, {1'b0, 8'h10}, 1'b1, 1'b1);
        issue(8'h12, 8'h34, 3'b001, 1'b0, {1'b0, 8'h36}, 1'b1, 1'b1);
        issue(8'hA5, 8'hFF, 3'b010, 1'b0, {1'b0, 8'h5A}, 1'b0, 1'b1);
        drain();
        check("b2b_accepts", 32'(acc_q.size()), 32'd3);
        if (acc_q.size() == 3) begin
            check("b2b_gap1", 32'(acc_q[1] - acc_q[0]), 32'd10);
            check("b2b_gap2", 32'(acc_q[2] - acc_q[1]), 32'd10);
        end

        // Reset mid-RUN after bit 3
        issue(8'hCA, 8'h5F, 3'b010, 1'b0, '0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_valid", 32'(out_valid), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        issue(8'hF0, 8'h3C, 3'b000, 1'b0, {1'b0, 8'h30}, 1'b0, 1'b1);
        drain();

        // Request held across reset deassertion, with a changed opsel
        rst_n = 1'b0;
        in_op1 = 8'h3C;
        in_op2 = 8'h00;
        in_opsel = 3'b011;
        in_cin = 1'b0;
        in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("inreset_in_ready", 32'(in_ready), 32'd1);
            check("inreset_busy", 32'(busy), 32'd0);
            check("inreset_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back({1'b0, 8'hC3});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("post_reset_accept", 32'(busy), 32'd1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
